// File: rtl/cpu_pkg.sv
// Shared decode/scoreboard types: issue kinds and the bypass stage entry.
// Optional bubble counter in cpu_scoreboard is enabled by defining CPU_SB_PERF_EN.
package cpu_pkg;

  localparam int CPU_NUM_REGS = 32;
  localparam int CPU_REG_W    = $clog2(CPU_NUM_REGS);

  typedef enum logic [1:0] {
    IK_SIMPLE = 2'd0,
    IK_LOAD   = 2'd1,
    IK_LONG   = 2'd2
  } issue_kind_t;

  typedef struct packed {
    logic [CPU_REG_W-1:0] reg_d;
    logic                 wen;
    logic                 load;
  } sb_stage_t;

endpackage

// File: rtl/cpu_sb_pending.sv
// Pending-register scoreboard for long-latency ops that write back out of band.
// Exposes the pending view with this cycle's write-back already released.
module cpu_sb_pending
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_LONG = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        set_en,
  input  logic [$clog2(NUM_REGS)-1:0] set_reg,
  input  logic                        clr_en,
  input  logic [$clog2(NUM_REGS)-1:0] clr_reg,
  output logic [NUM_REGS-1:0]         pending_eff,
  output logic                        long_full,
  output logic                        full_eff
);

  localparam int CW = $clog2(MAX_LONG + 1);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] clear_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] pending_next;
  logic [CW-1:0]       count;
  logic                clr_hit;

  // A write-back for a register that is not pending is ignored entirely.
  assign clr_hit     = clr_en && pending[clr_reg];
  assign clear_mask  = clr_hit ? (NUM_REGS'(1) << clr_reg) : '0;
  assign set_mask    = set_en ? (NUM_REGS'(1) << set_reg) : '0;
  assign pending_eff = pending & ~clear_mask;
  assign long_full   = (count == CW'(MAX_LONG));
  assign full_eff    = long_full && !clr_hit;

  always_comb begin
    pending_next    = pending_eff | set_mask;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_next;
      case ({set_en, clr_hit})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_clr_pending : assert property (@(posedge clock) disable iff (reset)
    clr_en |-> pending[clr_reg]);
  a_no_underflow : assert property (@(posedge clock) disable iff (reset)
    (count == '0) |-> !(clr_hit && !set_en));
  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    long_full |-> !(set_en && !clr_hit));

endmodule

// File: rtl/cpu_scoreboard.sv
// Decode-stage hazard/bypass controller: stage pipe, forward select and bubble logic.
// Define CPU_SB_PERF_EN to build the saturating bubble-cycle counter.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int BYPASS_STAGES = 2,
  parameter int MAX_LONG      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        p2_valid,
  input  logic [1:0]                  p2_kind,
  input  logic [$clog2(NUM_REGS)-1:0] p2_reg_a,
  input  logic [$clog2(NUM_REGS)-1:0] p2_reg_b,
  input  logic                        p2_use_a,
  input  logic                        p2_use_b,
  input  logic [$clog2(NUM_REGS)-1:0] p2_reg_d,
  input  logic                        p2_write_en,
  input  logic                        lw_valid,
  input  logic [$clog2(NUM_REGS)-1:0] lw_reg_d,
  output logic                        p2_bubble,
  output logic                        p2_issue,
  output logic [BYPASS_STAGES-1:0]    p2_bypass_a,
  output logic [BYPASS_STAGES-1:0]    p2_bypass_b,
  output logic                        long_full,
  output logic [31:0]                 perf_bubbles
);

  issue_kind_t         kind;
  sb_stage_t           stage_pipe [BYPASS_STAGES];
  sb_stage_t           stage_in;
  logic [NUM_REGS-1:0] pending_eff;
  logic                full_eff;
  logic                is_long;
  logic                dest_ok;
  logic                hazard;
  logic                load_hit_a, load_hit_b;
  logic [BYPASS_STAGES-1:0] match_a, match_b, sel_a, sel_b;

  assign kind    = issue_kind_t'(p2_kind);
  assign is_long = (kind == IK_LONG);
  assign dest_ok = p2_write_en && (p2_reg_d != '0);

  genvar gi;
  generate
    for (gi = 0; gi < BYPASS_STAGES; gi++) begin : g_match
      assign match_a[gi] = p2_use_a && (p2_reg_a != '0) && stage_pipe[gi].wen &&
                           (stage_pipe[gi].reg_d == CPU_REG_W'(p2_reg_a));
      assign match_b[gi] = p2_use_b && (p2_reg_b != '0) && stage_pipe[gi].wen &&
                           (stage_pipe[gi].reg_d == CPU_REG_W'(p2_reg_b));
    end
  endgenerate

  // Isolate the lowest set bit: the youngest producer wins.
  assign sel_a      = match_a & (~match_a + BYPASS_STAGES'(1));
  assign sel_b      = match_b & (~match_b + BYPASS_STAGES'(1));
  assign load_hit_a = match_a[0] && stage_pipe[0].load;
  assign load_hit_b = match_b[0] && stage_pipe[0].load;

  assign hazard = load_hit_a || load_hit_b
               || (p2_use_a && pending_eff[p2_reg_a])
               || (p2_use_b && pending_eff[p2_reg_b])
               || (dest_ok && pending_eff[p2_reg_d])
               || (is_long && full_eff);

  assign p2_bubble   = p2_valid && !flush && !reset && hazard;
  assign p2_issue    = p2_valid && !flush && !reset && !hazard && !stall;
  assign p2_bypass_a = (reset || load_hit_a) ? '0 : sel_a;
  assign p2_bypass_b = (reset || load_hit_b) ? '0 : sel_b;

  // Long ops never enter the bypass pipe; their results arrive via lw_valid.
  always_comb begin
    stage_in.reg_d = CPU_REG_W'(p2_reg_d);
    stage_in.wen   = p2_issue && !is_long && dest_ok;
    stage_in.load  = (kind == IK_LOAD);
  end

  generate
    for (gi = 0; gi < BYPASS_STAGES; gi++) begin : g_stage
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          stage_pipe[gi] <= '0;
        end else if (!stall) begin
          if (gi == 0) begin
            stage_pipe[gi] <= stage_in;
          end else begin
            stage_pipe[gi] <= stage_pipe[(gi > 0) ? gi - 1 : 0];
          end
        end
      end
    end
  endgenerate

  // Count only tracks ops that will later write back, so a long op without a destination is not counted.
  cpu_sb_pending #(
    .NUM_REGS (NUM_REGS),
    .MAX_LONG (MAX_LONG)
  ) u_pending (
    .clock       (clock),
    .reset       (reset),
    .set_en      (p2_issue && is_long && dest_ok),
    .set_reg     (p2_reg_d),
    .clr_en      (lw_valid),
    .clr_reg     (lw_reg_d),
    .pending_eff (pending_eff),
    .long_full   (long_full),
    .full_eff    (full_eff)
  );

`ifdef CPU_SB_PERF_EN
  logic [31:0] perf_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_count <= '0;
    end else if (p2_bubble && !stall && (perf_count != '1)) begin
      perf_count <= perf_count + 32'd1;
    end
  end

  assign perf_bubbles = perf_count;
`else
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Directed bench for cpu_scoreboard: expectations queued per step, popped and checked mid-cycle.
// Perf counter expectation follows CPU_SB_PERF_EN.
module tb_cpu_scoreboard;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       reset, stall, flush, p2_valid, p2_use_a, p2_use_b, p2_write_en, lw_valid;
  logic [1:0] p2_kind;
  logic [4:0] p2_reg_a, p2_reg_b, p2_reg_d, lw_reg_d;
  logic       p2_bubble, p2_issue, long_full;
  logic [1:0] p2_bypass_a, p2_bypass_b;
  logic [31:0] perf_bubbles;

  typedef struct {
    string      tag;
    logic       bubble;
    logic       issue;
    logic [1:0] ba;
    logic [1:0] bb;
    logic       full;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_perf = 0;

  always #5 clock = ~clock;

  cpu_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .p2_valid     (p2_valid),
    .p2_kind      (p2_kind),
    .p2_reg_a     (p2_reg_a),
    .p2_reg_b     (p2_reg_b),
    .p2_use_a     (p2_use_a),
    .p2_use_b     (p2_use_b),
    .p2_reg_d     (p2_reg_d),
    .p2_write_en  (p2_write_en),
    .lw_valid     (lw_valid),
    .lw_reg_d     (lw_reg_d),
    .p2_bubble    (p2_bubble),
    .p2_issue     (p2_issue),
    .p2_bypass_a  (p2_bypass_a),
    .p2_bypass_b  (p2_bypass_b),
    .long_full    (long_full),
    .perf_bubbles (perf_bubbles)
  );

  task automatic ins(input logic [1:0] kind, input logic [4:0] rd, input logic wen,
                     input logic [4:0] ra, input logic ua, input logic [4:0] rb, input logic ub);
    p2_valid = 1'b1; p2_kind = kind; p2_reg_d = rd; p2_write_en = wen;
    p2_reg_a = ra; p2_use_a = ua; p2_reg_b = rb; p2_use_b = ub;
  endtask

  task automatic expect_out(input string tag, input logic bub, input logic iss,
                            input logic [1:0] ba, input logic [1:0] bb, input logic full);
    exp_t e;
    e.tag = tag; e.bubble = bub; e.issue = iss; e.ba = ba; e.bb = bb; e.full = full;
    exp_q.push_back(e);
    if (bub && !stall && !reset) exp_perf++;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    e = exp_q.pop_front();
    checks++;
    assert (p2_bubble === e.bubble) else begin
      failures++; $error("FAIL %s bubble got=%0b exp=%0b", e.tag, p2_bubble, e.bubble);
    end
    checks++;
    assert (p2_issue === e.issue) else begin
      failures++; $error("FAIL %s issue got=%0b exp=%0b", e.tag, p2_issue, e.issue);
    end
    checks++;
    assert (p2_bypass_a === e.ba) else begin
      failures++; $error("FAIL %s bypass_a got=%b exp=%b", e.tag, p2_bypass_a, e.ba);
    end
    checks++;
    assert (p2_bypass_b === e.bb) else begin
      failures++; $error("FAIL %s bypass_b got=%b exp=%b", e.tag, p2_bypass_b, e.bb);
    end
    checks++;
    assert (long_full === e.full) else begin
      failures++; $error("FAIL %s long_full got=%0b exp=%0b", e.tag, long_full, e.full);
    end
    $display("step %-10s bubble=%0b issue=%0b byp_a=%b byp_b=%b full=%0b",
             e.tag, p2_bubble, p2_issue, p2_bypass_a, p2_bypass_b, long_full);
    @(posedge clock);
    #1;
  endtask

  task automatic check_perf(input string tag);
    logic [31:0] want;
`ifdef CPU_SB_PERF_EN
    want = 32'(exp_perf);
`else
    want = 32'd0;
`endif
    checks++;
    assert (perf_bubbles === want) else begin
      failures++; $error("FAIL %s perf_bubbles got=%0d exp=%0d", tag, perf_bubbles, want);
    end
    $display("step %-10s perf_bubbles=%0d", tag, perf_bubbles);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; lw_valid = 1'b0; lw_reg_d = '0;
    ins(IK_SIMPLE, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    expect_out("reset", 0, 0, 2'b00, 2'b00, 0); tick();
    reset = 1'b0;
    exp_perf = 0;
    check_perf("perf_rst");

    // Simple forwarding, then one stage older, then youngest-wins.
    ins(IK_SIMPLE, 5'd3, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
    expect_out("add3", 0, 1, 2'b00, 2'b00, 0); tick();
    ins(IK_SIMPLE, 5'd6, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1);
    expect_out("fwd_s0", 0, 1, 2'b01, 2'b00, 0); tick();
    ins(IK_SIMPLE, 5'd7, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1);
    expect_out("fwd_s1", 0, 1, 2'b10, 2'b01, 0); tick();
    ins(IK_SIMPLE, 5'd7, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0);
    expect_out("fwd_s1b", 0, 1, 2'b10, 2'b00, 0); tick();
    ins(IK_SIMPLE, 5'd2, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0);
    expect_out("youngest", 0, 1, 2'b01, 2'b00, 0); tick();

    // Load-use: one bubble, then forward from stage 1.
    ins(IK_LOAD, 5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
    expect_out("ld5", 0, 1, 2'b00, 2'b00, 0); tick();
    ins(IK_SIMPLE, 5'd9, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1);
    expect_out("ld_use", 1, 0, 2'b00, 2'b10, 0); tick();
    expect_out("ld_fwd", 0, 1, 2'b10, 2'b00, 0); tick();

    // Long op and same-cycle release; stall keeps the bubble but not the count.
    ins(IK_LONG, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_out("div7", 0, 1, 2'b00, 2'b00, 0); tick();
    ins(IK_SIMPLE, 5'd12, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
    expect_out("wait7", 1, 0, 2'b00, 2'b00, 0); tick();
    stall = 1'b1;
    expect_out("wait7_st", 1, 0, 2'b00, 2'b00, 0); tick();
    stall = 1'b0; lw_valid = 1'b1; lw_reg_d = 5'd7;
    expect_out("release7", 0, 1, 2'b00, 2'b00, 0); tick();
    lw_valid = 1'b0;

    // Fill the long-op scoreboard.
    for (int r = 8; r < 12; r++) begin
      ins(IK_LONG, 5'(r), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      expect_out($sformatf("long%0d", r), 0, 1, 2'b00, 2'b00, 0); tick();
    end
    ins(IK_LONG, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_out("full", 1, 0, 2'b00, 2'b00, 1); tick();
    lw_valid = 1'b1; lw_reg_d = 5'd9;
    expect_out("full_rel", 0, 1, 2'b00, 2'b00, 1); tick();
    lw_valid = 1'b0;

    // WAW, flush of a hazarding P2, pending unchanged afterwards.
    ins(IK_SIMPLE, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_out("waw10", 1, 0, 2'b00, 2'b00, 1); tick();
    flush = 1'b1;
    expect_out("flush", 0, 0, 2'b00, 2'b00, 1); tick();
    flush = 1'b0;
    ins(IK_SIMPLE, 5'd14, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0);
    expect_out("post_fl", 1, 0, 2'b00, 2'b00, 1); tick();
    check_perf("perf_cnt");

    // Asynchronous reset with long ops outstanding.
    reset = 1'b1;
    #1;
    exp_perf = 0;
    expect_out("rst_mid", 0, 0, 2'b00, 2'b00, 0); tick();
    check_perf("perf_clr");
    reset = 1'b0;

    // Register $0 is never pending nor bypassed.
    ins(IK_SIMPLE, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    expect_out("wr0", 0, 1, 2'b00, 2'b00, 0); tick();
    ins(IK_LONG, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    expect_out("long0", 0, 1, 2'b00, 2'b00, 0); tick();
    ins(IK_SIMPLE, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    expect_out("rd0", 0, 1, 2'b00, 2'b00, 0); tick();
    ins(IK_LONG, 5'd10, 1'b1, 5'd8, 1'b1, 5'd11, 1'b1);
    expect_out("post_rst", 0, 1, 2'b00, 2'b00, 0); tick();
    p2_valid = 1'b0;

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++; $error("FAIL queue_drain left=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
